driver_sevenseg_mux: RTL and testbench
======================================

Name: driver_sevenseg_mux

Overview:
- Multiplexed driver for a DIGITS-wide common-anode/cathode seven-segment display with per-digit decimal point.
- Scans digits on the shared timer `tick`, inserting a one-tick blanking gap between digits to suppress ghosting.
- Adds per-digit blinking, blank masking, optional leading-zero suppression and atomic data load.
- Sits between register/status logic and the board display pins, as the multi-digit successor of the single-digit decoder.

Parameters:
- DIGITS, 4, number of digits scanned; allowed range 1..8.
- SHOW_TICKS, 4, ticks each digit stays lit; minimum 1.
- BLINK_TICKS, 250, ticks per blink half-period; minimum 1.
- SEG_ACTIVE_LOW, 0, 1 inverts all `seg` outputs.
- AN_ACTIVE_LOW, 0, 1 inverts all `an` outputs.

Ports:
- aclk  in  1  clock, 20 MHz, rising edge.
- areset  in  1  asynchronous reset, active-high.
- tick  in  1  timer strobe; 1 for one aclk cycle every N cycles.
- en  in  1  enable; asynchronous to aclk, active-high.
- load  in  1  latch `data`, `dots`, `blank` and `blink` into shadow registers this cycle.
- data  in  4*DIGITS  hex nibbles; digit 0 is in [3:0].
- dots  in  DIGITS  decimal point per digit.
- blank  in  DIGITS  1 forces the digit dark, including its dot.
- blink  in  DIGITS  1 makes the digit blink.
- lzs  in  1  leading-zero suppression enable; live input, not shadowed.
- seg  out  8  {dp,g,f,e,d,c,b,a}.
- an  out  DIGITS  digit select, one-hot or all inactive.
- frame_done  out  1  one-cycle pulse when the last digit's SHOW period ends.

Behaviour:
- Reset (areset=1, asynchronous):
  - Shadow registers cleared; FSM in OFF; idx=0; show counter, blink counter and blink phase cleared.
  - `seg` and `an` driven to their inactive levels (all 0 before polarity inversion); frame_done=0.
- en synchronisation:
  - `en` passes through a 2-flop synchroniser to give en_s; all logic uses en_s.
  - Latency from an `en` edge to an FSM reaction is 2-3 cycles.
- Shadow registers:
  - Updated on any cycle with load=1, independent of FSM state.
  - Display reads only the shadow registers, so an update never tears within a frame.
- FSM states:
  - OFF: `an` all inactive. en_s=1 moves to BLANK with idx=0.
  - BLANK: `an` all inactive. On tick, move to SHOW.
  - SHOW: `an[idx]` active; show counter increments on each tick. On the tick that brings it to SHOW_TICKS, the counter clears and the FSM moves to BLANK.
    - idx advances to idx+1, wrapping DIGITS-1 to 0.
    - frame_done pulses when the wrap occurs.
  - Any state: en_s=0 moves to OFF next cycle; idx and show counter clear; blink counter holds.
- Outputs:
  - Registered; they reflect the state/idx one cycle after the transition.
  - DIGITS=1: behaves identically, with idx fixed at 0.
- Segment decode:
  - Standard hex 0-F (A, b, C, d, E, F forms). Example codes before inversion: 0=0x3F, 8=0x7F, F=0x71.
  - dp = dots[idx].
- Digit dark conditions (all segments including dp inactive while `an[idx]` stays active) when any of:
  - blank[idx]=1;
  - blink[idx]=1 and blink phase=1;
  - lzs=1, idx>0, and digit idx plus all higher digits are zero. Digit 0 is never suppressed.
- Blink:
  - Counter runs on tick while en_s=1.
  - Phase toggles every BLINK_TICKS ticks; phase starts at 0 (lit).
- Simultaneous events:
  - tick together with en_s falling: OFF wins.
  - load together with a SHOW output update: the new shadow is used from the next cycle.

Decomposition:
- Package sevenseg_pkg holds:
  - SEG_* bit-index constants;
  - the 16-entry hex-to-segment function;
  - FSM state enum typedef (OFF, BLANK, SHOW).
- One sub-module, sync_2ff, for the `en` synchroniser.
- Decode and scan stay in the top module.

Test Plan:
- Reset and idle: areset pulse mid-SHOW -> same cycle seg=0x00, an=0, frame_done=0; with en=0 the outputs stay idle indefinitely.
- Scan order: DIGITS=4, SHOW_TICKS=2, data=0x1234, en=1 -> sequence per digit is BLANK (1 tick) then SHOW (2 ticks).
  - Expected (an, seg) pairs, in order: (0001, 0x66 "4"), (0010, 0x4F "3"), (0100, 0x5B "2"), (1000, 0x06 "1").
  - frame_done pulses once per 12 ticks.
- Atomic load: change `data` while load=0 -> display unchanged; load=1 with data=0xABCD -> digit 0 shows 0x5E ("d") on its next SHOW.
- Leading-zero suppression: lzs=1, data=0x0050 -> digits 3 and 2 dark; digit 1 shows 0x6D ("5"); digit 0 shows 0x3F ("0").
  - data=0x0000 -> only digit 0 lit, showing 0x3F.
- Blink/blank: BLINK_TICKS=8, blink=0001, dots=0001 -> digit 0 (segments and dp) alternates lit/dark every 8 ticks.
  - blank=0010 -> digit 1 is always dark while an[1] is still active.
- Enable drop: deassert en mid-SHOW on idx=2 -> within 3 cycles an=0 and seg=0.
  - Re-enable -> scan restarts at idx=0 after one BLANK tick.
  - Polarity check: repeat with SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1 -> all outputs bitwise inverted, including reset values.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - seven-segment bit positions, hex decode and scan states
package sevenseg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Returns {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/driver_sevenseg_mux.sv
// rtl/driver_sevenseg_mux.sv - multiplexed seven-segment scanner with blanking gap,
// blink, blank mask, leading-zero suppression and shadowed data load
module driver_sevenseg_mux
  import sevenseg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SHOW_TICKS     = 4,
  parameter int BLINK_TICKS    = 250,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  tick,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dots,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lzs,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SC_W  = $clog2(SHOW_TICKS + 1);
  localparam int BC_W  = $clog2(BLINK_TICKS + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic                en_s;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dots;
  logic [DIGITS-1:0]   sh_blank;
  logic [DIGITS-1:0]   sh_blink;

  scan_state_t         state;
  logic [IDX_W-1:0]    idx;
  logic [SC_W-1:0]     show_cnt;
  logic [BC_W-1:0]     blink_cnt;
  logic                blink_phase;

  sync_2ff u_en_sync (
    .clk (aclk),
    .rst (areset),
    .d   (en),
    .q   (en_s)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sh_data  <= '0;
      sh_dots  <= '0;
      sh_blank <= '0;
      sh_blink <= '0;
    end else if (load) begin
      sh_data  <= data;
      sh_dots  <= dots;
      sh_blank <= blank;
      sh_blink <= blink;
    end
  end

  // Losing en_s overrides any tick seen in the same cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= ST_OFF;
      idx        <= '0;
      show_cnt   <= '0;
      frame_done <= 1'b0;
    end else if (!en_s) begin
      state      <= ST_OFF;
      idx        <= '0;
      show_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_OFF: begin
          state <= ST_BLANK;
          idx   <= '0;
        end
        ST_BLANK: begin
          if (tick) state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (tick) begin
            if (show_cnt == SC_W'(SHOW_TICKS - 1)) begin
              show_cnt <= '0;
              state    <= ST_BLANK;
              if (idx == LAST_IDX) begin
                idx        <= '0;
                frame_done <= 1'b1;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              show_cnt <= show_cnt + SC_W'(1);
            end
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  // Blink timebase holds across enable drops so the rhythm is not restarted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (en_s && tick) begin
      if (blink_cnt == BC_W'(BLINK_TICKS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BC_W'(1);
      end
    end
  end

  logic [DIGITS-1:0] upper_zero;
  logic              zero_run;
  logic [3:0]        cur_nib;
  logic              dark;
  logic [7:0]        seg_log;
  logic [DIGITS-1:0] an_log;

  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (sh_data[4*i +: 4] == 4'd0);
      upper_zero[i] = zero_run;
    end
  end

  always_comb begin
    cur_nib = sh_data[4*int'(idx) +: 4];
    dark    = sh_blank[idx]
            || (sh_blink[idx] && blink_phase)
            || (lzs && (idx != '0) && upper_zero[idx]);
    seg_log = '0;
    an_log  = '0;
    if (en_s && state == ST_SHOW) begin
      for (int i = 0; i < DIGITS; i++) begin
        an_log[i] = (int'(idx) == i);
      end
      if (!dark) begin
        seg_log[SEG_G:SEG_A] = hex_to_seg(cur_nib);
        seg_log[SEG_DP]      = sh_dots[idx];
      end
    end
  end

  // Polarity is applied before the flop so the pins come straight from registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_log ^ SEG_OFF;
      an  <= an_log ^ AN_OFF;
    end
  end

endmodule

// File: tb/tb_driver_sevenseg_mux.sv
// tb/tb_driver_sevenseg_mux.sv - scoreboard bench for driver_sevenseg_mux, both polarities
module tb_driver_sevenseg_mux;

  localparam int DIGITS = 4;

  logic        aclk = 1'b0;
  logic        areset;
  logic        tick;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dots;
  logic [3:0]  blank;
  logic [3:0]  blink;
  logic        lzs;
  logic [7:0]  seg;
  logic [7:0]  seg_inv;
  logic [3:0]  an;
  logic [3:0]  an_inv;
  logic        frame_done;
  logic        frame_done_inv;

  always #25 aclk = ~aclk;

  driver_sevenseg_mux #(
    .DIGITS(DIGITS), .SHOW_TICKS(2), .BLINK_TICKS(8), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) u_dut (
    .aclk(aclk), .areset(areset), .tick(tick), .en(en), .load(load), .data(data),
    .dots(dots), .blank(blank), .blink(blink), .lzs(lzs), .seg(seg), .an(an),
    .frame_done(frame_done)
  );

  driver_sevenseg_mux #(
    .DIGITS(DIGITS), .SHOW_TICKS(2), .BLINK_TICKS(8), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) u_inv (
    .aclk(aclk), .areset(areset), .tick(tick), .en(en), .load(load), .data(data),
    .dots(dots), .blank(blank), .blink(blink), .lzs(lzs), .seg(seg_inv), .an(an_inv),
    .frame_done(frame_done_inv)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          frames = 0;
  int          frames_inv = 0;
  int          tj = 0;
  int          bt = 0;
  bit          en_on = 1'b0;
  logic [15:0] m_data;
  logic [3:0]  m_dots;
  logic [3:0]  m_blank;
  logic [3:0]  m_blink;
  logic [3:0]  an_prev = 4'h0;
  logic [7:0]  hex_lut [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] model_seg(input int i, input bit phase);
    logic [15:0] rest;
    rest = m_data >> (4 * i);
    if (m_blank[i] || (m_blink[i] && phase) || (lzs && i > 0 && rest == 16'h0))
      return 8'h00;
    return {m_dots[i], hex_lut[rest[3:0]][6:0]};
  endfunction

  // Each new digit select is matched against the next scoreboard entry.
  always @(negedge aclk) begin
    exp_t       e;
    logic [3:0] inv_a;
    logic [7:0] inv_s;
    if (an != an_prev && an != 4'h0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_an", {28'h0, an}, 32'h0);
      end else begin
        e     = exp_q.pop_front();
        inv_a = ~e.an;
        inv_s = ~e.seg;
        check("scan_an", {28'h0, an}, {28'h0, e.an});
        check("scan_seg", {24'h0, seg}, {24'h0, e.seg});
        check("inv_an", {28'h0, an_inv}, {28'h0, inv_a});
        check("inv_seg", {24'h0, seg_inv}, {24'h0, inv_s});
      end
    end
    an_prev = an;
    if (frame_done) frames++;
    if (frame_done_inv) frames_inv++;
  end

  task automatic do_ticks(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      tick = 1'b1;
      if (en_on) begin
        tj++;
        bt++;
        if ((tj - 1) % 3 == 0) begin
          e.an  = 4'b0001 << (((tj - 1) / 3) % DIGITS);
          e.seg = model_seg(((tj - 1) / 3) % DIGITS, ((bt / 8) % 2) == 1);
          exp_q.push_back(e);
        end
      end
      @(negedge aclk);
      tick = 1'b0;
      repeat (2) @(negedge aclk);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bk,
                         input logic [3:0] bl);
    @(negedge aclk);
    data = d; dots = dp; blank = bk; blink = bl; load = 1'b1;
    m_data = d; m_dots = dp; m_blank = bk; m_blink = bl;
    @(negedge aclk);
    load = 1'b0;
  endtask

  task automatic enable_on();
    @(negedge aclk);
    en = 1'b1;
    en_on = 1'b1;
    tj = 0;
    repeat (5) @(negedge aclk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_an"}, {28'h0, an}, 32'h0);
    check({tag, "_seg"}, {24'h0, seg}, 32'h0);
    check({tag, "_fd"}, {31'h0, frame_done}, 32'h0);
    check({tag, "_an_inv"}, {28'h0, an_inv}, 32'hF);
    check({tag, "_seg_inv"}, {24'h0, seg_inv}, 32'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    areset = 1'b1; tick = 1'b0; en = 1'b0; load = 1'b0; lzs = 1'b0;
    data = 16'h0; dots = 4'h0; blank = 4'h0; blink = 4'h0;
    m_data = 16'h0; m_dots = 4'h0; m_blank = 4'h0; m_blink = 4'h0;
    repeat (3) @(negedge aclk);
    check_idle("reset");
    areset = 1'b0;

    // Disabled: ticks must not light anything.
    do_ticks(10);
    check_idle("idle");

    // Plain scan order and frame rate.
    do_load(16'h1234, 4'h0, 4'h0, 4'h0);
    enable_on();
    f0 = frames;
    do_ticks(24);
    check("frames_24", frames - f0, 2);
    check("frames_inv", frames_inv - f0, 2);

    // Unloaded data change is invisible; a load takes effect.
    @(negedge aclk);
    data = 16'hFFFF;
    do_ticks(12);
    do_load(16'hABCD, 4'h0, 4'h0, 4'h0);
    do_ticks(12);

    // Leading-zero suppression.
    lzs = 1'b1;
    do_load(16'h0050, 4'h0, 4'h0, 4'h0);
    do_ticks(12);
    do_load(16'h0000, 4'h0, 4'h0, 4'h0);
    do_ticks(12);
    lzs = 1'b0;

    // Blink on digit 0 with its dot, blank on digit 1.
    do_load(16'h1234, 4'b0001, 4'b0010, 4'b0001);
    do_ticks(48);

    // Enable drop while digit 2 is lit, then restart from digit 0.
    do_load(16'h1234, 4'h0, 4'h0, 4'h0);
    do_ticks(7);
    @(negedge aclk);
    en = 1'b0;
    en_on = 1'b0;
    repeat (3) @(negedge aclk);
    check_idle("en_drop");
    enable_on();
    f0 = frames;
    do_ticks(12);
    check("frames_restart", frames - f0, 1);

    // Asynchronous reset while a digit is lit.
    do_ticks(1);
    check("pre_reset_an", {28'h0, an}, 32'h1);
    @(negedge aclk);
    #2 areset = 1'b1;
    #1 check_idle("async_reset");
    @(negedge aclk);
    areset = 1'b0;
    m_data = 16'h0; m_dots = 4'h0; m_blank = 4'h0; m_blink = 4'h0;
    bt = 0;
    tj = 0;
    repeat (5) @(negedge aclk);
    do_ticks(12);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
